mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator-side load/store controller between the CPU pipeline and the word-organised data memory.
- Accepts one byte, halfword or word request at a time. Drives the memory's MemRead/MemWrite/address/write-data pins and returns aligned, extended load data.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the data memory; byte addresses at or above MEM_WORDS*4 are out of range
BASE_ADDR, 32'h0000_0000, byte address mapped to memory word 0

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  pipeline request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as error)
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse, response complete
resp_rdata  output  32  extended load data (0 for stores and errors)
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or reserved size
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
mem_addr  output  32  word-aligned byte address to memory, bits [1:0] always 0
mem_wdata  output  32  full word to write
mem_rdata  input  32  combinational memory read data

Behaviour:
Handshake and request capture:
- Accept on a rising edge with req_valid && req_ready.
- Capture the request fields into internal registers; request inputs are ignored after acceptance.
- req_ready = (state == IDLE).

States: IDLE, RD, WR, RESP.
- IDLE -> RESP on error; no memory access occurs.
- IDLE -> RD for a load or a sub-word store.
- IDLE -> WR for a word store.
- RD -> RESP for a load.
- RD -> WR for a sub-word store.
- WR -> RESP.
- RESP -> IDLE unconditionally.

Memory-side outputs:
- MemRead = (state == RD); MemWrite = (state == WR). They are never high together and are derived only from registered state.
- mem_addr = {captured_addr[31:2], 2'b00} - BASE_ADDR in RD and WR; 0 otherwise.
- mem_wdata is held stable for the whole WR cycle.

Load data:
- mem_rdata is captured at the end of RD.
- Byte lane is selected by addr[1:0], little-endian; halfword by addr[1].
- Extension follows req_unsigned.

Stores:
- Sub-word store: the RD-captured word with the selected lane(s) replaced by req_wdata[7:0] or req_wdata[15:0] becomes mem_wdata.
- Word store: mem_wdata = req_wdata.

Errors:
- Halfword with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
- addr < BASE_ADDR or addr >= BASE_ADDR + MEM_WORDS*4 is out of range.
- req_size = 3 is an error.

Latency from acceptance edge to resp_valid high:
- Load: 2 cycles.
- Word store: 2 cycles.
- Sub-word store: 3 cycles.
- Error: 1 cycle.
- Back-to-back throughput is one request per (latency + 1) cycles.

Response: resp_valid is high exactly one cycle (RESP); resp_rdata and resp_err are valid only while resp_valid is high, 0 otherwise.

Reset:
- rst_n low at an edge: state IDLE, all captured registers 0.
- Outputs: req_ready 1 after reset; resp_valid, resp_rdata, resp_err, MemRead, MemWrite, mem_addr and mem_wdata all 0.
- Reset during RD aborts the operation with memory unchanged.
- Reset during WR: that cycle's write has already been presented, so memory holds the new word; no response is issued.

Optional Feature:
MEM_ALIGN_CHECK_EN:
- Defined: misaligned requests produce resp_err as described above.
- Undefined: misalignment is not checked. Low address bits below the access size are forced to 0 (halfword clears bit 0, word clears bits [1:0]) and the access proceeds normally. Range and reserved-size errors are still reported.

Test Plan:
- Load word: memory word 3 = 32'h8899_AABB; lw addr 0x0C -> MemRead high for one cycle with mem_addr 0x0C; resp_valid 2 cycles after accept; resp_rdata 32'h8899_AABB, resp_err 0.
- Byte and halfword loads on the same word: lb addr 0x0D -> 32'hFFFF_FFAA; lbu 0x0D -> 32'h0000_00AA; lh 0x0E -> 32'hFFFF_8899; lhu 0x0E -> 32'h0000_8899.
- Store byte (RMW): word 3 = 32'h8899_AABB; sb addr 0x0E, wdata 0x12 -> RD then WR; mem_wdata 32'h8812_AABB; MemWrite high one cycle; resp after 3 cycles; following lw 0x0C returns 32'h8812_AABB.
- Errors with macro defined:
  - sw addr 0x0A -> resp_err 1 after 1 cycle; MemRead and MemWrite stay 0.
  - lw addr 0x100 (MEM_WORDS = 64) -> resp_err 1.
  - Without the macro, sw addr 0x0A writes word 2.
- Handshake and reset:
  - req_valid held high for two loads -> second accepted only after RESP, when req_ready returns to 1.
  - rst_n low during RD of an sh -> memory unchanged, no resp_valid, all outputs 0, req_ready 1 on the next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU pipeline and a word-organised data memory.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, misaligned requests are errors;
// otherwise the low address bits below the access size are cleared and the access proceeds.
module mem_access_ctrl #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;

    localparam logic [31:0] SPAN_BYTES = 32'(MEM_WORDS * 4);

    state_t      state, state_nxt;
    logic        accept;

    logic        cap_write;
    size_t       cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_err;
    logic [31:0] rd_word;

    logic [31:0] req_addr_eff;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] addr_offset;

    assign accept = req_valid && (state == IDLE);

    // Request classification on the raw inputs, valid in the acceptance cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        req_addr_eff = req_addr;
        misaligned   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
`else
        case (req_size)
            2'd1:    req_addr_eff[0]   = 1'b0;
            2'd2:    req_addr_eff[1:0] = 2'b00;
            default: req_addr_eff      = req_addr;
        endcase
`endif
        // Underflow below BASE_ADDR shows up as bit 32 of the 33-bit offset.
        addr_offset  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        out_of_range = addr_offset[32] || (addr_offset[31:0] >= SPAN_BYTES);
        req_err      = misaligned || out_of_range || (req_size == 2'd3);
    end

    always_ff @(posedge clk) begin
        // NOTE: the reset here is synchronous and clears every captured register, not just state.
        if (!rst_n) begin
            state        <= IDLE;
            cap_write    <= 1'b0;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_err      <= 1'b0;
            rd_word      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            if (accept) begin
                cap_write    <= req_write;
                cap_size     <= size_t'(req_size);
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr_eff;
                cap_wdata    <= req_wdata;
                cap_err      <= req_err;
            end
            if (state == RD) begin
                rd_word <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (!req_write || (req_size != 2'd2)) begin
                        state_nxt = RD;
                    end else begin
                        state_nxt = WR;
                    end
                end
            end
            RD:      state_nxt = cap_write ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sub-word stores merge the new lane(s) into the word fetched during RD.
    logic [31:0] merged_word;
    always_comb begin
        merged_word = rd_word;
        case (cap_size)
            SZ_BYTE: merged_word[{cap_addr[1:0], 3'b000} +: 8]  = cap_wdata[7:0];
            SZ_HALF: merged_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            default: merged_word = cap_wdata;
        endcase
    end

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    always_comb begin
        lane_byte = rd_word[{cap_addr[1:0], 3'b000} +: 8];
        lane_half = rd_word[{cap_addr[1], 4'b0000} +: 16];
        case (cap_size)
            SZ_BYTE: load_data = {{24{~cap_unsigned & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~cap_unsigned & lane_half[15]}}, lane_half};
            default: load_data = rd_word;
        endcase
    end

    // All outputs decode from registered state and captured fields only.
    always_comb begin
        req_ready  = (state == IDLE);
        MemRead    = (state == RD);
        MemWrite   = (state == WR);
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = (state == RESP);
        resp_err   = 1'b0;
        resp_rdata = '0;
        if ((state == RD) || (state == WR)) begin
            mem_addr = {cap_addr[31:2], 2'b00} - BASE_ADDR;
        end
        if (state == WR) begin
            mem_wdata = merged_word;
        end
        if (state == RESP) begin
            resp_err = cap_err;
            if (!cap_write && !cap_err) begin
                resp_rdata = load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural word memory.
// Expectations for misaligned requests follow MEM_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Word memory: writes on the edge while MemWrite is high, combinational read.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        both;
        logic        pulse_long;
    } txn_t;

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = 6'(idx);
        poke_val = val;
        @(posedge clk); #1;
        poke_en  = 1'b0;
    endtask

    // Issues one request and observes the memory side and response; lat 0 means no response.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, output txn_t t);
        int guard;
        t = '{rdata: 32'h0, err: 1'b0, lat: 0, rd_cyc: 0, wr_cyc: 0, rd_addr: 32'h0,
              wr_addr: 32'h0, wr_data: 32'h0, both: 1'b0, pulse_long: 1'b0};
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        // Scramble request inputs; the controller must use its captured copy.
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = ~wdata;
        for (int k = 1; k <= 8; k++) begin
            if (MemRead) begin t.rd_cyc++; t.rd_addr = mem_addr; end
            if (MemWrite) begin t.wr_cyc++; t.wr_addr = mem_addr; t.wr_data = mem_wdata; end
            if (MemRead && MemWrite) t.both = 1'b1;
            if (resp_valid) begin
                t.lat   = k;
                t.rdata = resp_rdata;
                t.err   = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (t.lat != 0) begin
            @(posedge clk); #1;
            t.pulse_long = resp_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b0000 ||
            resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, all expected 0",
                     resp_valid, resp_err, MemRead, MemWrite, resp_rdata, mem_addr, mem_wdata);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        txn_t t;
        poke(3, 32'h8899_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, t);
        tests_run++;
        if (t.rdata !== 32'h8899_AABB || t.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_data: got %h err %b expected 8899aabb err 0", t.rdata, t.err);
        end
        tests_run++;
        if (t.lat != 2) begin
            tests_failed++;
            $display("FAIL lw_latency: got %0d expected 2", t.lat);
        end
        tests_run++;
        if (t.rd_cyc != 1 || t.wr_cyc != 0 || t.rd_addr !== 32'h0000_000C) begin
            tests_failed++;
            $display("FAIL lw_mem_side: rd_cycles %0d wr_cycles %0d addr %h expected 1 0 0000000c",
                     t.rd_cyc, t.wr_cyc, t.rd_addr);
        end
        tests_run++;
        if (t.pulse_long !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_resp_pulse: valid after RESP %b ready %b expected 0 1", t.pulse_long, req_ready);
        end
    endtask

    task automatic test_subword_loads();
        txn_t t;
        logic [1:0]  sz   [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic        un   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad   [7] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E, 32'h0C, 32'h0F, 32'h0C};
        logic [31:0] expv [7] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899,
                                  32'hFFFF_FFBB, 32'h0000_0088, 32'hFFFF_AABB};
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, t);
            tests_run++;
            if (t.rdata !== expv[i] || t.err !== 1'b0 || t.lat != 2) begin
                tests_failed++;
                $display("FAIL subword_load_%0d: got %h err %b lat %0d expected %h err 0 lat 2",
                         i, t.rdata, t.err, t.lat, expv[i]);
            end
        end
    endtask

    task automatic test_store_byte();
        txn_t t;
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_000E, 32'hFFFF_FF12, t);
        tests_run++;
        if (t.wr_data !== 32'h8812_AABB || t.wr_addr !== 32'h0000_000C) begin
            tests_failed++;
            $display("FAIL sb_wdata: got %h at %h expected 8812aabb at 0000000c", t.wr_data, t.wr_addr);
        end
        tests_run++;
        if (t.lat != 3 || t.rd_cyc != 1 || t.wr_cyc != 1 || t.both !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_sequence: lat %0d rd %0d wr %0d both %b expected 3 1 1 0",
                     t.lat, t.rd_cyc, t.wr_cyc, t.both);
        end
        tests_run++;
        if (t.rdata !== 32'h0 || t.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_resp: rdata %h err %b expected 0 0", t.rdata, t.err);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, t);
        tests_run++;
        if (t.rdata !== 32'h8812_AABB) begin
            tests_failed++;
            $display("FAIL sb_readback: got %h expected 8812aabb", t.rdata);
        end
    endtask

    task automatic test_store_half();
        txn_t t;
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_000C, 32'h1234_5678, t);
        tests_run++;
        if (t.wr_data !== 32'h8812_5678 || t.lat != 3) begin
            tests_failed++;
            $display("FAIL sh_wdata: got %h lat %0d expected 88125678 lat 3", t.wr_data, t.lat);
        end
        tests_run++;
        if (mem[3] !== 32'h8812_5678) begin
            tests_failed++;
            $display("FAIL sh_memory: got %h expected 88125678", mem[3]);
        end
    endtask

    task automatic test_word_store();
        txn_t t;
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, t);
        tests_run++;
        if (t.lat != 2 || t.rd_cyc != 0 || t.wr_cyc != 1 || t.wr_addr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL sw_sequence: lat %0d rd %0d wr %0d addr %h expected 2 0 1 00000010",
                     t.lat, t.rd_cyc, t.wr_cyc, t.wr_addr);
        end
        tests_run++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL sw_memory: got %h expected deadbeef", mem[4]);
        end
    endtask

    task automatic test_errors();
        txn_t t;
        poke(63, 32'h0BAD_F00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_00FC, 32'h0, t);
        tests_run++;
        if (t.rdata !== 32'h0BAD_F00D || t.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word_load: got %h err %b expected 0badf00d err 0", t.rdata, t.err);
        end
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_00FF, 32'h0, t);
        tests_run++;
        if (t.rdata !== 32'h0000_000B || t.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_byte_load: got %h err %b expected 0000000b err 0", t.rdata, t.err);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, t);
        tests_run++;
        if (t.err !== 1'b1 || t.lat != 1 || t.rd_cyc != 0 || t.wr_cyc != 0 || t.rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL range_err: err %b lat %0d rd %0d wr %0d rdata %h expected 1 1 0 0 0",
                     t.err, t.lat, t.rd_cyc, t.wr_cyc, t.rdata);
        end
        do_req(1'b1, 2'd3, 1'b0, 32'h0000_000C, 32'h5555_5555, t);
        tests_run++;
        if (t.err !== 1'b1 || t.lat != 1 || t.wr_cyc != 0 || mem[3] !== 32'h8812_5678) begin
            tests_failed++;
            $display("FAIL size3_err: err %b lat %0d wr %0d mem %h expected 1 1 0 88125678",
                     t.err, t.lat, t.wr_cyc, mem[3]);
        end
    endtask

    task automatic test_misaligned();
        txn_t t;
        poke(2, 32'h1111_1111);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_000A, 32'hCAFE_BABE, t);
`ifdef MEM_ALIGN_CHECK_EN
        tests_run++;
        if (t.err !== 1'b1 || t.lat != 1 || t.rd_cyc != 0 || t.wr_cyc != 0 || mem[2] !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL misaligned_sw: err %b lat %0d rd %0d wr %0d mem %h expected 1 1 0 0 11111111",
                     t.err, t.lat, t.rd_cyc, t.wr_cyc, mem[2]);
        end
`else
        tests_run++;
        if (t.err !== 1'b0 || t.lat != 2 || t.wr_addr !== 32'h0000_0008 || mem[2] !== 32'hCAFE_BABE) begin
            tests_failed++;
            $display("FAIL misaligned_sw: err %b lat %0d addr %h mem %h expected 0 2 00000008 cafebabe",
                     t.err, t.lat, t.wr_addr, mem[2]);
        end
`endif
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_000F, 32'h0, t);
`ifdef MEM_ALIGN_CHECK_EN
        tests_run++;
        if (t.err !== 1'b1 || t.lat != 1 || t.rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL misaligned_lh: err %b lat %0d rdata %h expected 1 1 0", t.err, t.lat, t.rdata);
        end
`else
        tests_run++;
        if (t.err !== 1'b0 || t.lat != 2 || t.rdata !== 32'hFFFF_8812) begin
            tests_failed++;
            $display("FAIL misaligned_lh: err %b lat %0d rdata %h expected 0 2 ffff8812", t.err, t.lat, t.rdata);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int   resp_at [$];
        int   rd_count;
        logic ready_k1;
        logic ready_k3;
        rd_count     = 0;
        ready_k1     = 1'bx;
        ready_k3     = 1'bx;
        req_write    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_000C;
        req_wdata    = 32'h0;
        req_valid    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (resp_valid) resp_at.push_back(k);
            if (MemRead) rd_count++;
            if (k == 1) ready_k1 = req_ready;
            if (k == 3) ready_k3 = req_ready;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (resp_at.size() != 2 || resp_at[0] != 2 || resp_at[1] != 5) begin
            tests_failed++;
            $display("FAIL b2b_resp_timing: %0d pulses, expected 2 pulses at cycles 2 and 5", resp_at.size());
        end
        tests_run++;
        if (ready_k1 !== 1'b0 || ready_k3 !== 1'b1 || rd_count != 3) begin
            tests_failed++;
            $display("FAIL b2b_ready: ready@1 %b ready@3 %b reads %0d expected 0 1 3", ready_k1, ready_k3, rd_count);
        end
    endtask

    task automatic test_reset_mid_rd();
        logic saw_resp;
        logic saw_write;
        poke(5, 32'h5566_7788);
        req_write    = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0014;
        req_wdata    = 32'h0000_AAAA;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if (MemRead !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_rd_setup: MemRead %b expected 1", MemRead);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b0000 || resp_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_rd_outputs: valid %b err %b rd %b wr %b addr %h wdata %h ready %b expected zeros, ready 1",
                     resp_valid, resp_err, MemRead, MemWrite, mem_addr, mem_wdata, req_ready);
        end
        rst_n     = 1'b1;
        saw_resp  = 1'b0;
        saw_write = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
            if (MemWrite) saw_write = 1'b1;
        end
        tests_run++;
        if (saw_resp !== 1'b0 || saw_write !== 1'b0 || mem[5] !== 32'h5566_7788) begin
            tests_failed++;
            $display("FAIL rst_rd_abort: resp %b write %b mem %h expected 0 0 55667788", saw_resp, saw_write, mem[5]);
        end
    endtask

    task automatic test_reset_mid_wr();
        logic saw_resp;
        poke(6, 32'h0000_0000);
        req_write    = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0018;
        req_wdata    = 32'h0F0F_0F0F;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if (MemWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wr_setup: MemWrite %b expected 1", MemWrite);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        saw_resp = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        tests_run++;
        if (saw_resp !== 1'b0 || mem[6] !== 32'h0F0F_0F0F) begin
            tests_failed++;
            $display("FAIL rst_wr_commit: resp %b mem %h expected 0 0f0f0f0f", saw_resp, mem[6]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        poke_en      = 1'b0;
        poke_idx     = 6'd0;
        poke_val     = 32'h0;
        #1;
        for (int i = 0; i < MEM_WORDS; i++) poke(i, 32'h0);
        test_reset();
        test_load_word();
        test_subword_loads();
        test_store_byte();
        test_store_half();
        test_word_store();
        test_errors();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_rd();
        test_reset_mid_wr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
